usb_rx_packet_parser: RTL and testbench

Receive-side counterpart of the TX packet compiler. It consumes the byte stream from the USB RX decoder (one strobe per byte, one EOP pulse per packet) and checks the PID. For token packets it extracts address and endpoint; for data packets it strips the trailing CRC16 and streams the payload into the RX data buffer; for handshake packets it only reports the PID. One status pulse per packet reports the PID, the payload byte count and any error, for the USB protocol controller.

---
 rtl/usb_rx_pkg.sv | 61 ++++++
 rtl/usb_rx_crc.sv | 42 ++++
 rtl/usb_rx_packet_parser.sv | 234 +++++++++++++++++++++++
 tb/tb_usb_rx_packet_parser.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB RX packet parser: PIDs, FSM states,
// error codes and CRC polynomials/residuals.
package usb_rx_pkg;

   localparam logic [3:0] PID_OUT   = 4'h1;
   localparam logic [3:0] PID_IN    = 4'h9;
   localparam logic [3:0] PID_SETUP = 4'hD;
   localparam logic [3:0] PID_DATA0 = 4'h3;
   localparam logic [3:0] PID_DATA1 = 4'hB;
   localparam logic [3:0] PID_ACK   = 4'h2;
   localparam logic [3:0] PID_NAK   = 4'hA;
   localparam logic [3:0] PID_STALL = 4'hE;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PID,
      ST_TOKEN,
      ST_DATA,
      ST_HSHAKE,
      ST_DISCARD,
      ST_DONE
   } rx_state_t;

   typedef enum logic [2:0] {
      ERR_NONE  = 3'd0,
      ERR_PID   = 3'd1,
      ERR_LEN   = 3'd2,
      ERR_CRC   = 3'd3,
      ERR_OVF   = 3'd4,
      ERR_STUFF = 3'd5
   } rx_err_t;

   typedef enum logic [1:0] {
      PK_BAD,
      PK_TOKEN,
      PK_DATA,
      PK_HSHAKE
   } pid_class_t;

   localparam logic [4:0]  CRC5_POLY      = 5'h05;
   localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
   localparam logic [15:0] CRC16_POLY     = 16'h8005;
   localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

   // Upper nibble must be the complement of the lower one, and only the
   // PIDs this device understands are accepted.
   function automatic pid_class_t pid_class(input logic [7:0] b);
      pid_class_t c;
      c = PK_BAD;
      if (b[7:4] == ~b[3:0]) begin
         case (b[3:0])
            PID_OUT, PID_IN, PID_SETUP: c = PK_TOKEN;
            PID_DATA0, PID_DATA1:       c = PK_DATA;
            PID_ACK, PID_NAK, PID_STALL: c = PK_HSHAKE;
            default:                    c = PK_BAD;
         endcase
      end
      return c;
   endfunction

endpackage

// File: rtl/usb_rx_crc.sv
// Byte-parallel USB CRC register, LSB-first, MSB-feedback form, all-ones seed.
// Checking the residual after the transmitted CRC bits validates the packet.
module usb_rx_crc
   import usb_rx_pkg::*;
#(
   parameter int               WIDTH = 5,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(5)
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             init,
   input  logic             en,
   input  logic [7:0]       data,
   output logic [WIDTH-1:0] crc
);

   logic [WIDTH-1:0] crc_nxt;
   logic             fb;

   always_comb begin
      crc_nxt = crc;
      fb      = 1'b0;
      for (int i = 0; i < 8; i++) begin
         fb      = crc_nxt[WIDTH-1] ^ data[i];
         crc_nxt = {crc_nxt[WIDTH-2:0], 1'b0};
         if (fb) begin
            crc_nxt = crc_nxt ^ POLY;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         crc <= '1;
      end else if (init) begin
         crc <= '1;
      end else if (en) begin
         crc <= crc_nxt;
      end
   end

endmodule

// File: rtl/usb_rx_packet_parser.sv
// USB RX packet parser: PID check, token field extraction, data payload
// streaming with CRC16 stripping. Optional CRC checking: USB_RX_CRC_CHECK_EN.
module usb_rx_packet_parser
   import usb_rx_pkg::*;
#(
   parameter int MAX_DATA = 64,
   parameter int OCC_W    = 7
) (
   input  logic             clk,
   input  logic             n_rst,
   // Byte interface: byte_ready_RX is a one-cycle strobe qualifying byte_RX,
   // no backpressure; eop_RX and stuff_err_RX are one-cycle pulses.
   input  logic             byte_ready_RX,
   input  logic [7:0]       byte_RX,
   input  logic             eop_RX,
   input  logic             stuff_err_RX,
   input  logic [OCC_W-1:0] Buffer_Occupancy,
   output logic             Store_RX_Packet_Data,
   output logic [7:0]       RX_Packet_Data,
   output logic             packet_done_RX,
   output logic [3:0]       pid_RX,
   output logic [6:0]       addr_RX,
   output logic [3:0]       endp_RX,
   output logic [OCC_W-1:0] data_count_RX,
   output rx_err_t          err_RX
);

   localparam logic [OCC_W-1:0] MAX_CNT = OCC_W'(MAX_DATA);

   rx_state_t        state;
   rx_err_t          err_q;
   rx_err_t          eop_err;
   pid_class_t       pclass;
   logic [7:0]       pid_byte;
   logic [1:0]       byte_cnt;
   logic [7:0]       hold0;
   logic [7:0]       hold1;
   logic [7:0]       tok_b1;
   logic [2:0]       tok_endp_hi;
   logic             tok_pkt;
   logic [OCC_W-1:0] pay_cnt;
   logic             crc5_bad;
   logic             crc16_bad;

`ifdef USB_RX_CRC_CHECK_EN
   logic        crc_init;
   logic        crc_en;
   logic [4:0]  crc5;
   logic [15:0] crc16;

   assign crc_init = (state == ST_PID);
   assign crc_en   = byte_ready_RX && ((state == ST_TOKEN) || (state == ST_DATA));

   usb_rx_crc #(.WIDTH(5), .POLY(CRC5_POLY)) u_crc5 (
      .clk   (clk),
      .n_rst (n_rst),
      .init  (crc_init),
      .en    (crc_en),
      .data  (byte_RX),
      .crc   (crc5)
   );

   usb_rx_crc #(.WIDTH(16), .POLY(CRC16_POLY)) u_crc16 (
      .clk   (clk),
      .n_rst (n_rst),
      .init  (crc_init),
      .en    (crc_en),
      .data  (byte_RX),
      .crc   (crc16)
   );

   assign crc5_bad  = (crc5 != CRC5_RESIDUAL);
   assign crc16_bad = (crc16 != CRC16_RESIDUAL);
`else
   assign crc5_bad  = 1'b0;
   assign crc16_bad = 1'b0;
`endif

   assign pclass = pid_class(pid_byte);

   // Error reported if eop_RX arrives in the current state.
   always_comb begin
      eop_err = ERR_NONE;
      case (state)
         ST_IDLE: eop_err = ERR_LEN;
         ST_PID: begin
            if (pclass == PK_BAD)         eop_err = ERR_PID;
            else if (stuff_err_RX)        eop_err = ERR_STUFF;
            else if (pclass != PK_HSHAKE) eop_err = ERR_LEN;
         end
         ST_TOKEN: begin
            if (stuff_err_RX)           eop_err = ERR_STUFF;
            else if (byte_cnt != 2'd2)  eop_err = ERR_LEN;
            else if (crc5_bad)          eop_err = ERR_CRC;
         end
         ST_DATA: begin
            if (stuff_err_RX)           eop_err = ERR_STUFF;
            else if (byte_cnt != 2'd2)  eop_err = ERR_LEN;
            else if (crc16_bad)         eop_err = ERR_CRC;
         end
         ST_HSHAKE: begin
            if (stuff_err_RX) eop_err = ERR_STUFF;
         end
         ST_DISCARD: eop_err = err_q;
         default:    eop_err = ERR_NONE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state                <= ST_IDLE;
         err_q                <= ERR_NONE;
         pid_byte             <= '0;
         byte_cnt             <= '0;
         hold0                <= '0;
         hold1                <= '0;
         tok_b1               <= '0;
         tok_endp_hi          <= '0;
         tok_pkt              <= 1'b0;
         pay_cnt              <= '0;
         Store_RX_Packet_Data <= 1'b0;
         RX_Packet_Data       <= '0;
         packet_done_RX       <= 1'b0;
         pid_RX               <= '0;
         addr_RX              <= '0;
         endp_RX              <= '0;
         data_count_RX        <= '0;
         err_RX               <= ERR_NONE;
      end else begin
         Store_RX_Packet_Data <= 1'b0;
         packet_done_RX       <= 1'b0;
         if (eop_RX && (state != ST_DONE)) begin
            // Results are registered on the EOP edge so the pulse lands one clock later.
            state          <= ST_DONE;
            packet_done_RX <= 1'b1;
            err_RX         <= eop_err;
            pid_RX         <= (state == ST_IDLE) ? 4'h0 : pid_byte[3:0];
            data_count_RX  <= (state == ST_IDLE) ? '0 : pay_cnt;
            if ((state != ST_IDLE) && tok_pkt && (byte_cnt == 2'd2)) begin
               addr_RX <= tok_b1[6:0];
               endp_RX <= {tok_endp_hi, tok_b1[7]};
            end
         end else begin
            case (state)
               ST_IDLE: begin
                  if (byte_ready_RX) begin
                     pid_byte <= byte_RX;
                     byte_cnt <= '0;
                     pay_cnt  <= '0;
                     tok_pkt  <= 1'b0;
                     err_q    <= ERR_NONE;
                     state    <= ST_PID;
                  end
               end
               ST_PID: begin
                  if (pclass == PK_BAD) begin
                     err_q <= ERR_PID;
                     state <= ST_DISCARD;
                  end else if (stuff_err_RX) begin
                     err_q <= ERR_STUFF;
                     state <= ST_DISCARD;
                  end else begin
                     tok_pkt <= (pclass == PK_TOKEN);
                     case (pclass)
                        PK_TOKEN: state <= ST_TOKEN;
                        PK_DATA:  state <= ST_DATA;
                        default:  state <= ST_HSHAKE;
                     endcase
                  end
               end
               ST_TOKEN: begin
                  if (stuff_err_RX) begin
                     err_q <= ERR_STUFF;
                     state <= ST_DISCARD;
                  end else if (byte_ready_RX) begin
                     case (byte_cnt)
                        2'd0: begin
                           tok_b1   <= byte_RX;
                           byte_cnt <= 2'd1;
                        end
                        2'd1: begin
                           tok_endp_hi <= byte_RX[2:0];
                           byte_cnt    <= 2'd2;
                        end
                        default: begin
                           err_q <= ERR_LEN;
                           state <= ST_DISCARD;
                        end
                     endcase
                  end
               end
               ST_DATA: begin
                  if (stuff_err_RX) begin
                     err_q <= ERR_STUFF;
                     state <= ST_DISCARD;
                  end else if (byte_ready_RX) begin
                     // The two newest bytes stay held: at EOP they are the CRC16.
                     if (byte_cnt != 2'd2) begin
                        if (byte_cnt == 2'd0) hold0 <= byte_RX;
                        else                  hold1 <= byte_RX;
                        byte_cnt <= byte_cnt + 2'd1;
                     end else if (pay_cnt == MAX_CNT) begin
                        err_q <= ERR_LEN;
                        state <= ST_DISCARD;
                     end else if (Buffer_Occupancy == MAX_CNT) begin
                        err_q <= ERR_OVF;
                        state <= ST_DISCARD;
                     end else begin
                        Store_RX_Packet_Data <= 1'b1;
                        RX_Packet_Data       <= hold0;
                        hold0                <= hold1;
                        hold1                <= byte_RX;
                        pay_cnt              <= pay_cnt + 1'b1;
                     end
                  end
               end
               ST_HSHAKE: begin
                  if (stuff_err_RX) begin
                     err_q <= ERR_STUFF;
                     state <= ST_DISCARD;
                  end else if (byte_ready_RX) begin
                     err_q <= ERR_LEN;
                     state <= ST_DISCARD;
                  end
               end
               ST_DISCARD: state <= ST_DISCARD;
               ST_DONE:    state <= ST_IDLE;
               default:    state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_usb_rx_packet_parser.sv
// Directed-vector bench for usb_rx_packet_parser with a queue-based scoreboard;
// CRC-error vectors are added when USB_RX_CRC_CHECK_EN is defined.
module tb_usb_rx_packet_parser;
   import usb_rx_pkg::*;

   localparam int MAX_DATA = 64;
   localparam int OCC_W    = 7;

   logic             clk;
   logic             n_rst;
   logic             byte_ready_RX;
   logic [7:0]       byte_RX;
   logic             eop_RX;
   logic             stuff_err_RX;
   logic [OCC_W-1:0] Buffer_Occupancy;
   logic             Store_RX_Packet_Data;
   logic [7:0]       RX_Packet_Data;
   logic             packet_done_RX;
   logic [3:0]       pid_RX;
   logic [6:0]       addr_RX;
   logic [3:0]       endp_RX;
   logic [OCC_W-1:0] data_count_RX;
   logic [2:0]       err_RX;

   int total = 0;
   int bad   = 0;

   // Expected packet word: {pid_chk, pid[3:0], addr[6:0], endp[3:0], cnt[6:0], err[2:0]}
   logic [7:0]  exp_data_q[$];
   logic [25:0] exp_pkt_q[$];
   logic [7:0]  tx_q[$];
   logic [6:0]  last_addr = '0;
   logic [3:0]  last_endp = '0;

   usb_rx_packet_parser #(.MAX_DATA(MAX_DATA), .OCC_W(OCC_W)) dut (
      .clk                  (clk),
      .n_rst                (n_rst),
      .byte_ready_RX        (byte_ready_RX),
      .byte_RX              (byte_RX),
      .eop_RX               (eop_RX),
      .stuff_err_RX         (stuff_err_RX),
      .Buffer_Occupancy     (Buffer_Occupancy),
      .Store_RX_Packet_Data (Store_RX_Packet_Data),
      .RX_Packet_Data       (RX_Packet_Data),
      .packet_done_RX       (packet_done_RX),
      .pid_RX               (pid_RX),
      .addr_RX              (addr_RX),
      .endp_RX              (endp_RX),
      .data_count_RX        (data_count_RX),
      .err_RX               (err_RX)
   );

   // Clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   // Driver tasks
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      byte_RX       = b;
      byte_ready_RX = 1'b1;
      @(negedge clk);
      byte_ready_RX = 1'b0;
   endtask

   task automatic send_eop();
      @(negedge clk);
      eop_RX = 1'b1;
      @(negedge clk);
      eop_RX = 1'b0;
   endtask

   task automatic pulse_stuff();
      @(negedge clk);
      stuff_err_RX = 1'b1;
      @(negedge clk);
      stuff_err_RX = 1'b0;
   endtask

   task automatic send_bytes();
      foreach (tx_q[i]) send_byte(tx_q[i]);
   endtask

   task automatic exp_pkt(input logic pc, input logic [3:0] pid, input logic tok,
                          input logic [6:0] a, input logic [3:0] e,
                          input int cnt, input logic [2:0] err);
      if (tok) begin
         last_addr = a;
         last_endp = e;
      end
      exp_pkt_q.push_back({pc, pid, last_addr, last_endp, 7'(cnt), err});
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while ((exp_pkt_q.size() != 0) && (n < 20)) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk({nm, "_done_pending"}, exp_pkt_q.size(), 0);
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_store"}, Store_RX_Packet_Data, 0);
      chk({nm, "_data"},  RX_Packet_Data, 0);
      chk({nm, "_done"},  packet_done_RX, 0);
      chk({nm, "_pid"},   pid_RX, 0);
      chk({nm, "_addr"},  addr_RX, 0);
      chk({nm, "_endp"},  endp_RX, 0);
      chk({nm, "_count"}, data_count_RX, 0);
      chk({nm, "_err"},   err_RX, 0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      logic [7:0]  ed;
      logic [25:0] ep;
      if (n_rst) begin
         if (Store_RX_Packet_Data) begin
            if (exp_data_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_push: got 0x%0h want no push", RX_Packet_Data);
            end else begin
               ed = exp_data_q.pop_front();
               chk("push_data", RX_Packet_Data, ed);
            end
         end
         if (packet_done_RX) begin
            if (exp_pkt_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got packet_done_RX=1 want 0");
            end else begin
               ep = exp_pkt_q.pop_front();
               if (ep[25]) chk("pid_RX", pid_RX, ep[24:21]);
               chk("addr_RX", addr_RX, ep[20:14]);
               chk("endp_RX", endp_RX, ep[13:10]);
               chk("data_count_RX", data_count_RX, ep[9:3]);
               chk("err_RX", err_RX, ep[2:0]);
               chk("pushes_missing", exp_data_q.size(), 0);
            end
         end
      end
   end

   // Stimulus
   initial begin
      n_rst            = 1'b0;
      byte_ready_RX    = 1'b0;
      byte_RX          = '0;
      eop_RX           = 1'b0;
      stuff_err_RX     = 1'b0;
      Buffer_Occupancy = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      n_rst = 1'b1;
      repeat (2) @(negedge clk);

      // SETUP addr 0 endp 0
      tx_q = '{8'h2D, 8'h00, 8'h10};
      exp_pkt(1'b1, 4'hD, 1'b1, 7'h00, 4'h0, 0, ERR_NONE);
      send_bytes(); send_eop(); wait_done("setup");

`ifndef USB_RX_CRC_CHECK_EN
      // IN addr 0x15 endp 5: endp[0] rides in b1[7], endp[3:1] in b2[2:0]
      tx_q = '{8'h69, 8'h95, 8'hA2};
      exp_pkt(1'b1, 4'h9, 1'b1, 7'h15, 4'h5, 0, ERR_NONE);
      send_bytes(); send_eop(); wait_done("in_token");
`endif

      // DATA0 GET_DESCRIPTOR setup payload
      tx_q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
      exp_data_q = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
      exp_pkt(1'b1, 4'h3, 1'b0, 7'h0, 4'h0, 8, ERR_NONE);
      send_bytes(); send_eop(); wait_done("data0");

`ifdef USB_RX_CRC_CHECK_EN
      tx_q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h95};
      exp_data_q = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
      exp_pkt(1'b1, 4'h3, 1'b0, 7'h0, 4'h0, 8, ERR_CRC);
      send_bytes(); send_eop(); wait_done("data0_badcrc");
`endif

      // Zero-length DATA1
      tx_q = '{8'h4B, 8'h00, 8'h00};
      exp_pkt(1'b1, 4'hB, 1'b0, 7'h0, 4'h0, 0, ERR_NONE);
      send_bytes(); send_eop(); wait_done("data1_zlp");

      // ACK
      tx_q = '{8'hD2};
      exp_pkt(1'b1, 4'h2, 1'b0, 7'h0, 4'h0, 0, ERR_NONE);
      send_bytes(); send_eop(); wait_done("ack");

      // Bad PID check nibble, then two trailing bytes
      tx_q = '{8'hD3, 8'h11, 8'h22};
      exp_pkt(1'b0, 4'h0, 1'b0, 7'h0, 4'h0, 0, ERR_PID);
      send_bytes(); send_eop(); wait_done("bad_pid");

      // Short token: held addr/endp must not change
      tx_q = '{8'h2D, 8'h00};
      exp_pkt(1'b1, 4'hD, 1'b0, 7'h0, 4'h0, 0, ERR_LEN);
      send_bytes(); send_eop(); wait_done("short_token");

      // NAK followed by a stray byte
      tx_q = '{8'h5A, 8'h00};
      exp_pkt(1'b1, 4'hA, 1'b0, 7'h0, 4'h0, 0, ERR_LEN);
      send_bytes(); send_eop(); wait_done("nak_extra");

      // EOP with no bytes
      exp_pkt(1'b1, 4'h0, 1'b0, 7'h0, 4'h0, 0, ERR_LEN);
      send_eop(); wait_done("empty_eop");

      // Buffer one short of full: pushes proceed
      Buffer_Occupancy = 7'd63;
      tx_q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
      exp_data_q = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
      exp_pkt(1'b1, 4'h3, 1'b0, 7'h0, 4'h0, 8, ERR_NONE);
      send_bytes(); send_eop(); wait_done("occ63");

      // Buffer full at first push: suppressed, overflow
      Buffer_Occupancy = 7'd64;
      tx_q = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      exp_pkt(1'b1, 4'h3, 1'b0, 7'h0, 4'h0, 0, ERR_OVF);
      send_bytes(); send_eop(); wait_done("ovf");
      Buffer_Occupancy = '0;

      // 67 bytes after PID: 64 pushes, then the 65th push is a length error
      tx_q = {};
      tx_q.push_back(8'hC3);
      for (int i = 0; i < 67; i++) tx_q.push_back(8'(i));
      for (int i = 0; i < 64; i++) exp_data_q.push_back(8'(i));
      exp_pkt(1'b1, 4'h3, 1'b0, 7'h0, 4'h0, 64, ERR_LEN);
      send_bytes(); send_eop(); wait_done("too_long");

      // Stuff error mid-DATA after two pushes
      tx_q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01};
      exp_data_q = '{8'h80, 8'h06};
      exp_pkt(1'b1, 4'h3, 1'b0, 7'h0, 4'h0, 2, ERR_STUFF);
      send_bytes(); pulse_stuff();
      send_byte(8'h22); send_byte(8'h33);
      send_eop(); wait_done("stuff");

      // Reset mid-packet: two pushes happen, then no done
      tx_q = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h44};
      exp_data_q = '{8'h11, 8'h22};
      send_bytes();
      @(negedge clk);
      chk("pre_reset_pushes", exp_data_q.size(), 0);
      n_rst = 1'b0;
      @(negedge clk);
      check_zero("mid_reset");
      n_rst = 1'b1;
      last_addr = '0;
      last_endp = '0;
      repeat (6) @(negedge clk);

      tx_q = '{8'hD2};
      exp_pkt(1'b1, 4'h2, 1'b0, 7'h0, 4'h0, 0, ERR_NONE);
      send_bytes(); send_eop(); wait_done("post_reset_ack");

      tx_q = '{8'h4B, 8'h00, 8'h00};
      exp_pkt(1'b1, 4'hB, 1'b0, 7'h0, 4'h0, 0, ERR_NONE);
      send_bytes(); send_eop(); wait_done("post_reset_zlp");

      repeat (4) @(negedge clk);
      chk("data_q_empty", exp_data_q.size(), 0);
      chk("pkt_q_empty", exp_pkt_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
